ex_stage: RTL
=============

# ex_stage

Execute stage of the 16-bit five-stage static pipeline, between instruction decode and MEM. Each cycle it takes the decoded instruction and register operands, computes the ALU result, memory address or branch target, and updates the condition flags. It registers everything MEM consumes: the instruction, the result, store data, and `nf`/`zf`. It squashes its own output when MEM signals a taken branch and, optionally, forwards results from MEM and WB.

## Interface
Parameters:
- none (datapath fixed at 16 bits, data address 8 bits)

Ports:
- `clk`  in  1  clock, rising edge
- `reset`  in  1  asynchronous, active-low reset (asserted at 0)
- `cpu_state`  in  1  1 = exec (pipeline advances), 0 = idle (all state holds)
- `ex_input`  in  16  instruction from ID: [15:12] op, [11:8] rd, [7:4] ra, [3:0] rb/imm4
- `reg_A`  in  16  register-file value of `ex_input[7:4]`
- `reg_B`  in  16  register-file value of `ex_input[3:0]`
- `reg_C`  in  16  register-file value of `ex_input[11:8]` (STORE data)
- `flush`  in  1  taken branch in MEM (MEM's `is_branch`)
- `wb_input`  in  16  instruction currently in WB (forwarding)
- `dst_regC2`  in  16  WB write value (forwarding)
- `mem_input`  out  16  instruction passed to MEM
- `dst_regC1`  out  16  ALU result / address / branch target
- `store_reg2`  out  16  STORE data
- `nf`  out  1  negative flag
- `zf`  out  1  zero flag
- `halted`  out  1  sticky: HALT has passed through EX

## Operation
Opcodes: NOP 0000, HALT 0001, ADD 0010, CMP 0111, BN 1001, BZ 1011, LOAD 1101, STORE 1110. Any other opcode is treated as NOP.

Operands `A` and `B` are `reg_A` and `reg_B`, or forwarded values (see Configuration).

Per opcode, the value registered into `dst_regC1`:
- ADD: `A + B`, modulo 2^16, no carry kept.
- LOAD / STORE: `{8'h00, (A[7:0] + {4'h0, imm4}) mod 256}`.
- BN / BZ: `{8'h00, ex_input[7:0]}` (absolute target).
- CMP: `A - B`, modulo 2^16.
- NOP / HALT: 0.

Other per-opcode effects:
- STORE: `store_reg2 <= C` (forwarded like A/B); all other opcodes drive `store_reg2 <= 0`.
- CMP: `zf <= (A - B == 0)`, `nf <= (A - B)[15]`.
- All other opcodes hold `nf`/`zf`.
- HALT: sets `halted` to 1; it stays 1 until reset. Later instructions still advance.

Register writers (for forwarding): ADD and LOAD, destination `[11:8]`.

## Timing
- Reset (`reset`=0, asynchronous): `mem_input`, `dst_regC1`, `store_reg2` = 16'h0000; `nf`, `zf`, `halted` = 0.
- Latency is one cycle: inputs sampled at edge N appear on the outputs after edge N.
- The flags written by CMP are visible when the next instruction reaches MEM, so CMP immediately followed by BZ/BN branches correctly.
- `cpu_state`=0: every register holds, including the flags. `flush` is ignored.
- `flush`=1 with `cpu_state`=1:
  - `mem_input` <= NOP and `dst_regC1`, `store_reg2` <= 0.
  - Flags and `halted` are not updated. The squashed instruction has no effect.
- `reset` asserted mid-operation clears state on the same cycle regardless of `clk`. Release is synchronised externally.

## Configuration
- `EX_FORWARD_EN` defined: operand bypass. For each of ra, rb and rd (rd only for STORE data):
  - Priority 1: if `mem_input` is ADD and its `[11:8]` matches, use `dst_regC1`.
  - Otherwise, if `wb_input` is ADD or LOAD and its `[11:8]` matches, use `dst_regC2`.
  - Otherwise, use the register-file value.
  - LOAD in MEM is never a forwarding source; ID must stall that case.
- `EX_FORWARD_EN` undefined: `reg_A`, `reg_B`, `reg_C` are used directly. Software inserts NOPs for hazards, and `wb_input`/`dst_regC2` are unused.

## Test plan
- Reset released, `cpu_state`=1, ADD r1,r2,r3 with A=16'h7FFF, B=16'h0003 → after one edge `dst_regC1`=16'h8002, `mem_input`=16'h2123, flags still 0.
- CMP with A=B=16'h0042, then BZ 8'h30 → `zf`=1 and `nf`=0 after the CMP edge; BZ gives `dst_regC1`=16'h0030. CMP with A=1, B=2 → `nf`=1, `zf`=0.
- STORE r4,(r5+4'hF) with A=16'h00F8, C=16'hBEEF → `dst_regC1`=16'h0007 (address wraps), `store_reg2`=16'hBEEF.
- `flush`=1 while CMP (A=B) is in EX → `mem_input`=0, `dst_regC1`=0, `zf` unchanged. `cpu_state`=0 for 3 cycles → all outputs frozen.
- With `EX_FORWARD_EN` defined:
  - ADD r1 (result 16'h0010) followed by ADD r2,r1,r1 → second result 16'h0020.
  - Same dependency 2 slots apart via WB `dst_regC2`=16'h0005 → result 16'h000A.
- `reset`=0 asserted between clock edges after HALT → all outputs 0 and `halted`=0 immediately, with no clock edge needed.

Source files
------------

// File: rtl/ex_stage.sv
// ex_stage: 16-bit pipeline execute stage (ALU, address, branch target, flags); operand bypass when EX_FORWARD_EN is defined
module ex_stage (
    input  logic        clk,
    input  logic        reset,
    input  logic        cpu_state,
    input  logic [15:0] ex_input,
    input  logic [15:0] reg_A,
    input  logic [15:0] reg_B,
    input  logic [15:0] reg_C,
    input  logic        flush,
    input  logic [15:0] wb_input,
    input  logic [15:0] dst_regC2,
    output logic [15:0] mem_input,
    output logic [15:0] dst_regC1,
    output logic [15:0] store_reg2,
    output logic        nf,
    output logic        zf,
    output logic        halted
);
    localparam logic [3:0] OP_HALT  = 4'b0001;
    localparam logic [3:0] OP_ADD   = 4'b0010;
    localparam logic [3:0] OP_CMP   = 4'b0111;
    localparam logic [3:0] OP_BN    = 4'b1001;
    localparam logic [3:0] OP_BZ    = 4'b1011;
    localparam logic [3:0] OP_LOAD  = 4'b1101;
    localparam logic [3:0] OP_STORE = 4'b1110;

    logic [3:0]  op;
    logic [15:0] a, b, c;
    logic [15:0] diff;
    logic [7:0]  addr;
    logic [15:0] result;
    logic        fwd_unused;

    assign op = ex_input[15:12];

`ifdef EX_FORWARD_EN
    // MEM's ADD result wins over WB's ADD/LOAD result; a LOAD still in MEM is stalled by ID
    logic mem_wr, wb_wr;
    assign mem_wr = mem_input[15:12] == OP_ADD;
    assign wb_wr  = wb_input[15:12] == OP_ADD || wb_input[15:12] == OP_LOAD;
    assign a = (mem_wr && mem_input[11:8] == ex_input[7:4]) ? dst_regC1 :
               (wb_wr && wb_input[11:8] == ex_input[7:4]) ? dst_regC2 : reg_A;
    assign b = (mem_wr && mem_input[11:8] == ex_input[3:0]) ? dst_regC1 :
               (wb_wr && wb_input[11:8] == ex_input[3:0]) ? dst_regC2 : reg_B;
    assign c = (mem_wr && mem_input[11:8] == ex_input[11:8]) ? dst_regC1 :
               (wb_wr && wb_input[11:8] == ex_input[11:8]) ? dst_regC2 : reg_C;
    assign fwd_unused = ^wb_input[7:0];
`else
    // software schedules around hazards, so register-file values are used as-is
    assign a = reg_A;
    assign b = reg_B;
    assign c = reg_C;
    assign fwd_unused = ^{wb_input, dst_regC2};
`endif

    // per-opcode result; unknown opcodes behave as NOP
    always_comb begin
        diff   = a - b;
        addr   = a[7:0] + {4'h0, ex_input[3:0]};
        result = op == OP_ADD                      ? a + b :
                 (op == OP_LOAD || op == OP_STORE) ? {8'h00, addr} :
                 (op == OP_BN || op == OP_BZ)      ? {8'h00, ex_input[7:0]} :
                 op == OP_CMP                      ? diff : 16'h0000;
    end

    // EX/MEM register: holds when idle, squashes to NOP on a taken branch in MEM
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            mem_input  <= 16'h0000;
            dst_regC1  <= 16'h0000;
            store_reg2 <= 16'h0000;
            nf         <= 1'b0;
            zf         <= 1'b0;
            halted     <= 1'b0;
        end else if (cpu_state) begin
            if (flush) begin
                mem_input  <= 16'h0000;
                dst_regC1  <= 16'h0000;
                store_reg2 <= 16'h0000;
            end else begin
                mem_input  <= ex_input;
                dst_regC1  <= result;
                store_reg2 <= op == OP_STORE ? c : 16'h0000;
                if (op == OP_CMP) begin
                    nf <= diff[15];
                    zf <= diff == 16'h0000;
                end
                if (op == OP_HALT)
                    halted <= 1'b1;
            end
        end
    end
endmodule
